// File: rtl/lite16_pkg.sv
// Shared definitions for the 16-bit lite datapath: word width, arbiter FSM
// state encoding and requester identifiers.
package lite16_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester ids; also the encoding of the round-robin pointer.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LOAD  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// requester named by the pointer wins. Purely combinational.
module rr_pick2
  import lite16_pkg::*;
(
  input  logic req_f,
  input  logic req_l,
  input  logic ptr,
  output logic win,
  output logic any
);

  assign any = req_f | req_l;
  assign win = (req_f && req_l) ? ptr : (req_l ? REQ_LOAD : REQ_FETCH);

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates a fetch and a load requester onto one combinational-read ROM.
// Each access takes IDLE -> ACCESS -> RESP; the response strobe, data and
// error flag are all registered so they are clean for the whole RESP cycle.
module rom_arbiter
  import lite16_pkg::*;
#(
  parameter int ROM_DEPTH = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [WORD_W-1:0] f_addr,
  output logic              f_valid,
  output logic [WORD_W-1:0] f_data,
  input  logic              l_req,
  input  logic [WORD_W-1:0] l_addr,
  output logic              l_valid,
  output logic [WORD_W-1:0] l_data,
  output logic              err,
  output logic              busy,
  output logic [WORD_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data
);

  state_t            state;
  logic              ptr;
  logic              win_q;
  logic [WORD_W-1:0] addr_q;
  logic              pick_win;
  logic              pick_any;
  logic              oor;
  logic [WORD_W-1:0] rd_word;

  rr_pick2 u_pick (
    .req_f (f_req),
    .req_l (l_req),
    .ptr   (ptr),
    .win   (pick_win),
    .any   (pick_any)
  );

  // The ROM only ever sees the latched address, so requester address
  // changes never glitch onto the ROM bus.
  assign rom_addr = addr_q;

  // Out-of-range words read as zero regardless of what the ROM drives.
  assign oor     = int'({16'd0, addr_q}) >= ROM_DEPTH;
  assign rd_word = oor ? '0 : rom_data;

  // Access sequencer: grant in IDLE, read in ACCESS, present in RESP.
  // f_data/l_data are the per-requester read-data registers and hold
  // their value between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= REQ_FETCH;
      win_q   <= REQ_FETCH;
      addr_q  <= '0;
      f_data  <= '0;
      l_data  <= '0;
      f_valid <= 1'b0;
      l_valid <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state  <= ACCESS;
            busy   <= 1'b1;
            win_q  <= pick_win;
            // Pointer moves to whoever was not served this time.
            ptr    <= ~pick_win;
            addr_q <= (pick_win == REQ_LOAD) ? l_addr : f_addr;
          end
        end
        ACCESS: begin
          state   <= RESP;
          f_valid <= (win_q == REQ_FETCH);
          l_valid <= (win_q == REQ_LOAD);
          err     <= oor;
          if (win_q == REQ_FETCH) f_data <= rd_word;
          else                    l_data <= rd_word;
        end
        RESP: begin
          state   <= IDLE;
          busy    <= 1'b0;
          f_valid <= 1'b0;
          l_valid <= 1'b0;
          err     <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          f_valid <= 1'b0;
          l_valid <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: reset state, a table of single
// transactions, directed multi-cycle sequences, then randomized traffic
// checked against a transaction-level reference model.
module tb_rom_arbiter;

  localparam int DEPTH = 21;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_valid;
  logic [15:0] f_data;
  logic        l_req = 1'b0;
  logic [15:0] l_addr = '0;
  logic        l_valid;
  logic [15:0] l_data;
  logic        err;
  logic        busy;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in ROM: word[i] = A000+i. It also answers beyond DEPTH so the
  // arbiter's zeroing of out-of-range reads is actually exercised.
  assign rom_data = 16'hA000 + rom_addr;

  rom_arbiter #(.ROM_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_valid  (f_valid),
    .f_data   (f_data),
    .l_req    (l_req),
    .l_addr   (l_addr),
    .l_valid  (l_valid),
    .l_data   (l_data),
    .err      (err),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Leaves the bench at a negedge with rst just dropped: the current cycle
  // is the first IDLE cycle, and requests driven now are sampled.
  task automatic do_reset();
    rst = 1'b1; f_req = 1'b0; l_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    return (int'(a) < DEPTH) ? 16'hA000 + a : 16'h0000;
  endfunction

  function automatic logic [15:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 16'hFFFF;
    if (r == 1) return 16'($urandom);
    return 16'($urandom_range(0, 31));
  endfunction

  typedef struct {
    string       name;
    logic        fr;
    logic [15:0] fa;
    logic        lr;
    logic [15:0] la;
    logic        efv;
    logic        elv;
    logic [15:0] edata;
    logic        eerr;
  } vec_t;

  vec_t vecs[6];

  // Transaction-level model state for the random phase.
  int          free_at, resp_at, ptr_m, who_m;
  logic [15:0] addr_m, last_addr, fa_m, la_m, lastf, lastl;
  bit          pf, pl, hf, hl, efv, elv;

  int          ev_t[$];
  int          ev_who[$];
  logic [15:0] ev_d[$];

  initial begin
    vecs[0] = '{"single_fetch5",  1'b1, 16'd5,     1'b0, 16'd0,     1'b1, 1'b0, 16'hA005, 1'b0};
    vecs[1] = '{"single_load7",   1'b0, 16'd0,     1'b1, 16'd7,     1'b0, 1'b1, 16'hA007, 1'b0};
    vecs[2] = '{"load_oor_0x20",  1'b0, 16'd0,     1'b1, 16'h0020,  1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{"fetch_last20",   1'b1, 16'd20,    1'b0, 16'd0,     1'b1, 1'b0, 16'hA014, 1'b0};
    vecs[4] = '{"fetch_first_oor",1'b1, 16'd21,    1'b0, 16'd0,     1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{"both_fetch_wins",1'b1, 16'd3,     1'b1, 16'd7,     1'b1, 1'b0, 16'hA003, 1'b0};

    @(negedge clk);

    // Reset state while rst is held.
    rst = 1'b1;
    step();
    step();
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_l_valid", 32'(l_valid), 32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_rom_addr",32'(rom_addr),32'd0);

    // Single transactions from reset: request at N, response at N+2.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      f_req = vecs[i].fr; f_addr = vecs[i].fa;
      l_req = vecs[i].lr; l_addr = vecs[i].la;
      step();
      chk({vecs[i].name, "_access_valid"}, 32'({f_valid, l_valid}), 32'd0);
      chk({vecs[i].name, "_access_busy"},  32'(busy), 32'd1);
      step();
      chk({vecs[i].name, "_f_valid"}, 32'(f_valid), 32'(vecs[i].efv));
      chk({vecs[i].name, "_l_valid"}, 32'(l_valid), 32'(vecs[i].elv));
      chk({vecs[i].name, "_err"},     32'(err),     32'(vecs[i].eerr));
      chk({vecs[i].name, "_data"},    32'(vecs[i].efv ? f_data : l_data), 32'(vecs[i].edata));
      f_req = 1'b0; l_req = 1'b0;
      step();
      chk({vecs[i].name, "_idle_after"}, 32'({busy, f_valid, l_valid, err}), 32'd0);
    end

    // Simultaneous after reset: F first, then L three cycles later.
    do_reset();
    f_req = 1'b1; f_addr = 16'd3; l_req = 1'b1; l_addr = 16'd7;
    step(); step();
    chk("sim_f_first", 32'({f_valid, l_valid}), 32'b10);
    chk("sim_f_data",  32'(f_data), 32'hA003);
    f_req = 1'b0;
    step(); step();
    chk("sim_l_not_yet", 32'(l_valid), 32'd0);
    chk("sim_f_hold",    32'(f_data), 32'hA003);
    step();
    chk("sim_l_second", 32'({f_valid, l_valid}), 32'b01);
    chk("sim_l_data",   32'(l_data), 32'hA007);
    l_req = 1'b0;
    step();

    // Continuous contention for 12 cycles: F, L, F, L at 3-cycle spacing.
    do_reset();
    f_req = 1'b1; f_addr = 16'd2; l_req = 1'b1; l_addr = 16'd11;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (f_valid) begin ev_t.push_back(k); ev_who.push_back(0); ev_d.push_back(f_data); end
      if (l_valid) begin ev_t.push_back(k); ev_who.push_back(1); ev_d.push_back(l_data); end
    end
    f_req = 1'b0; l_req = 1'b0;
    chk("cont_count", 32'(ev_t.size()), 32'd4);
    for (int k = 0; k < 4 && k < ev_t.size(); k++) begin
      chk($sformatf("cont_time%0d", k), 32'(ev_t[k]), 32'(2 + 3 * k));
      chk($sformatf("cont_who%0d", k),  32'(ev_who[k]), 32'(k % 2));
      chk($sformatf("cont_data%0d", k), 32'(ev_d[k]), (k % 2 == 0) ? 32'hA002 : 32'hA00B);
    end
    step();

    // Reset during ACCESS aborts the access without a strobe.
    do_reset();
    f_req = 1'b1; f_addr = 16'd9;
    step();
    chk("rma_busy_access", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rma_busy_after",  32'(busy), 32'd0);
    chk("rma_valid_after", 32'({f_valid, l_valid, err}), 32'd0);
    chk("rma_addr_after",  32'(rom_addr), 32'd0);
    rst = 1'b0; f_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rma_quiet%0d", k), 32'({f_valid, l_valid, busy}), 32'd0);
    end
    f_req = 1'b1; f_addr = 16'd0;
    step(); step();
    chk("rma_refetch_valid", 32'(f_valid), 32'd1);
    chk("rma_refetch_data",  32'(f_data), 32'hA000);
    f_req = 1'b0;
    step();

    // Randomized traffic against the transaction-level model. Each
    // requester holds its request until it sees its strobe; the arbiter is
    // free again three cycles after a grant and the response lands two
    // cycles after the grant.
    do_reset();
    free_at = 0; resp_at = -100; ptr_m = 0; who_m = 0;
    addr_m = '0; last_addr = '0; fa_m = '0; la_m = '0;
    pf = 0; pl = 0; hf = 0; hl = 0; lastf = '0; lastl = '0;
    for (int t = 0; t < 800; t++) begin
      efv = (t == resp_at) && (who_m == 0);
      elv = (t == resp_at) && (who_m == 1);
      chk("rnd_f_valid", 32'(f_valid), 32'(efv));
      chk("rnd_l_valid", 32'(l_valid), 32'(elv));
      chk("rnd_busy",    32'(busy), 32'((t == resp_at - 1) || (t == resp_at)));
      chk("rnd_err",     32'(err),  32'((efv || elv) && int'(addr_m) >= DEPTH));
      chk("rnd_rom_addr",32'(rom_addr), 32'(last_addr));
      if (efv) begin
        lastf = exp_word(addr_m); hf = 1; pf = 0;
      end
      if (elv) begin
        lastl = exp_word(addr_m); hl = 1; pl = 0;
      end
      if (hf) chk("rnd_f_data", 32'(f_data), 32'(lastf));
      if (hl) chk("rnd_l_data", 32'(l_data), 32'(lastl));
      if (!pf && $urandom_range(0, 2) == 0) begin pf = 1; fa_m = rand_addr(); end
      if (!pl && $urandom_range(0, 2) == 0) begin pl = 1; la_m = rand_addr(); end
      f_req = pf; f_addr = pf ? fa_m : 16'($urandom);
      l_req = pl; l_addr = pl ? la_m : 16'($urandom);
      if (t >= free_at && (pf || pl)) begin
        who_m     = (pf && pl) ? ptr_m : (pl ? 1 : 0);
        ptr_m     = 1 - who_m;
        addr_m    = (who_m == 1) ? la_m : fa_m;
        last_addr = addr_m;
        resp_at   = t + 2;
        free_at   = t + 3;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ROM_DEPTH, default 65536, number of valid 16-bit ROM words; addresses >= ROM_DEPTH are out of range.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port f_req  input  1  fetch requester: request; address valid while high.
REQ-005 Port f_addr  input  16  fetch word address.
REQ-006 Port f_valid  output  1  fetch response strobe, one cycle.
REQ-007 Port f_data  output  16  fetch read data, meaningful only when f_valid=1.
REQ-008 Port l_req / l_addr / l_valid / l_data  in/in/out/out  1/16/1/16  load requester, same semantics as fetch.
REQ-009 Port err  output  1  pulses with the response valid when the served address was out of range.
REQ-010 Port busy  output  1  high in any state other than IDLE.
REQ-011 Port rom_addr  output  16  address to the combinational-read ROM.
REQ-012 Port rom_data  input  16  ROM read data, valid in the same cycle as rom_addr.

Function
REQ-013 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when f_req or l_req is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 Requests are sampled only in IDLE; a request raised during ACCESS or RESP waits for the next IDLE.
REQ-015 On IDLE->ACCESS: register the winner id and the winner's address into addr_q.
REQ-016 Arbitration: a single requester wins alone; with both high, the holder of the round-robin pointer wins.
REQ-017 Pointer resets to fetch, and after each grant points to the requester that was not served.
REQ-018 In ACCESS: rom_addr = addr_q; the arbiter registers rom_data (or 16'h0000 if addr_q >= ROM_DEPTH) into data_q and registers the out-of-range flag.
REQ-019 In IDLE and RESP: rom_addr holds addr_q (no glitching to requester addresses).
REQ-020 In RESP: the winner's valid=1 and its data=data_q, the other valid=0, and err = registered out-of-range flag.
REQ-021 Latency: req sampled in IDLE at cycle N produces valid in cycle N+2; maximum throughput is one access per 3 cycles.
REQ-022 The requester shall hold req and addr stable from assertion until it sees valid; a req still high in the IDLE cycle after RESP is a new request.
REQ-023 Back-to-back contention: with both requesters continuously high, grants alternate F, L, F, L.
REQ-024 Outputs f_data and l_data hold their last value when not valid; only the valid strobes are qualifiers.

Reset
REQ-025 rst high at a clock edge forces: state=IDLE, pointer=fetch, addr_q=0, data_q=0, f_valid=0, l_valid=0, err=0, busy=0.
REQ-026 Reset mid-operation (ACCESS or RESP) aborts the access, and no valid strobe is issued for it.
REQ-027 The first request is sampled in the first IDLE cycle after rst deasserts.

Structure
REQ-028 Shared package lite16_pkg holds the FSM state encoding (IDLE, ACCESS, RESP), the requester id constants (REQ_FETCH=0, REQ_LOAD=1), and the 16-bit word width constant.
REQ-029 One sub-module, rr_pick2: 2-way round-robin picker (inputs: two requests, pointer; outputs: winner id, grant-any).
REQ-030 The ROM itself stays outside this block; the top level connects rom_addr/rom_data to the existing rom module.

Verification
REQ-031 Bench uses the existing rom module loaded with a hex file where word[i] = 16'hA000+i and ROM_DEPTH=21.
REQ-032 Single fetch: f_req=1, f_addr=5 in IDLE at cycle N -> f_valid=1 and f_data=16'hA005 in cycle N+2, l_valid=0, err=0.
REQ-033 Simultaneous after reset: f_addr=3, l_addr=7 both asserted -> F is served first with 16'hA003, then L is served with 16'hA007 three cycles later.
REQ-034 Continuous contention for 12 cycles -> grant order F, L, F, L, with each valid exactly 3 cycles apart.
REQ-035 Out of range: l_addr=16'h0020 -> l_valid=1, l_data=16'h0000, err=1 for one cycle.
REQ-036 Reset mid-access: assert rst during ACCESS -> no valid in the following cycles; busy=0 and state=IDLE next cycle; a subsequent f_addr=0 returns 16'hA000.
